// File: rtl/ila_pkg.sv
// Shared types and constants for the integrated logic analyser.
package ila_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2,
    ST_DONE      = 2'd3
  } ila_state_e;

  localparam logic [19:0] OFF_CTRL      = 20'h0_0000;
  localparam logic [19:0] OFF_STATUS    = 20'h0_0004;
  localparam logic [19:0] OFF_POSTTRIG  = 20'h0_0008;
  localparam logic [19:0] OFF_TRIG_ADDR = 20'h0_000C;
  localparam logic [19:0] OFF_INFO      = 20'h0_0010;

  localparam logic [7:0]  INFO_MAGIC    = 8'h1A;

  function automatic logic [31:0] info_word(input int unsigned aw, input int unsigned sw);
    logic [31:0] a;
    logic [31:0] s;
    a = aw;
    s = sw;
    return {INFO_MAGIC, a[7:0], 8'h00, s[7:0]};
  endfunction

endpackage

// File: rtl/reg_map_pkg.sv
// Top-level register map: base addresses of the 1 MiB peripheral windows.
package reg_map_pkg;

  localparam logic [31:0] BASE_ILA = 32'h3000_0000;

endpackage

// File: rtl/ila_spram.sv
// Single-port sample buffer: synchronous write, asynchronous read so the
// bus read register sees the addressed entry in the same cycle.
module ila_spram #(
  parameter int AW = 10,
  parameter int DW = 21
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/ila.sv
// Integrated logic analyser on the register bus: circular capture, trigger,
// post-trigger countdown and host readback. Define ILA_EDGE_TRIG_EN for
// rising-edge triggering instead of level triggering.
//
//   state        | meaning
//   ST_IDLE      | no capture, buffer readable
//   ST_ARMED     | capturing every cycle, waiting for trigger or FORCE
//   ST_TRIGGERED | capturing the remaining post-trigger samples
//   ST_DONE      | buffer frozen, readable
module ila
  import ila_pkg::*;
#(
  parameter int          SAMPLE_W  = 21,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = reg_map_pkg::BASE_ILA
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                trigger_in,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [31:0]         bus_addr,
  input  logic                bus_wen,
  input  logic                bus_ren,
  input  logic [31:0]         bus_wdata,
  output logic [31:0]         bus_rdata
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  ila_state_e    state_q;
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] fill_q;
  logic [AW-1:0] post_cnt_q;
  logic [AW-1:0] trig_addr_q;
  logic [AW-1:0] posttrig_q;
  logic [31:0]   bus_rdata_q;
  logic [31:0]   rdata_d;

  logic [19:0]         off;
  logic                hit, buf_sel, capturing, prefill_ok, trig_cond;
  logic                wr_ctrl, arm, abort, frc, wr_pt;
  logic [AW-1:0]       pt_wval, ram_addr;
  logic                ram_we;
  logic [SAMPLE_W-1:0] ram_rdata;

  assign off     = bus_addr[19:0];
  assign hit     = (bus_addr[31:20] == BASE_ADDR[31:20]);
  assign buf_sel = off[19] && (off[18:2] < 17'(DEPTH));

  assign wr_ctrl = bus_wen && hit && (off == OFF_CTRL);
  assign arm     = wr_ctrl && bus_wdata[0];
  assign frc     = wr_ctrl && bus_wdata[1];
  assign abort   = wr_ctrl && bus_wdata[2];

  assign wr_pt   = bus_wen && hit && (off == OFF_POSTTRIG) &&
                   ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign pt_wval = (bus_wdata > 32'(DEPTH - 1)) ? LAST : bus_wdata[AW-1:0];

  assign capturing  = (state_q == ST_ARMED) || (state_q == ST_TRIGGERED);
  assign prefill_ok = (fill_q >= (LAST - posttrig_q));

`ifdef ILA_EDGE_TRIG_EN
  // Reset high so a trigger line already asserted never counts as an edge.
  logic trig_prev_q;

  always_ff @(posedge clk) begin
    if (rst) trig_prev_q <= 1'b1;
    else     trig_prev_q <= trigger_in;
  end

  assign trig_cond = trigger_in && !trig_prev_q;
`else
  assign trig_cond = trigger_in;
`endif

  assign ram_we   = capturing && !rst;
  assign ram_addr = capturing ? wr_ptr_q : bus_addr[AW+1:2];

  ila_spram #(
    .AW (AW),
    .DW (SAMPLE_W)
  ) u_buf (
    .clk_i   (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (sample_in),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      posttrig_q  <= AW'(DEPTH / 2);
    end else begin
      if (capturing) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (fill_q != LAST) fill_q <= fill_q + 1'b1;
      end
      if (wr_pt) posttrig_q <= pt_wval;

      if (arm) begin
        state_q    <= ST_ARMED;
        wr_ptr_q   <= '0;
        fill_q     <= '0;
        post_cnt_q <= '0;
      end else if (abort) begin
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_ARMED: begin
            if ((trig_cond && prefill_ok) || frc) begin
              trig_addr_q <= wr_ptr_q;
              post_cnt_q  <= posttrig_q;
              state_q     <= (posttrig_q == '0) ? ST_DONE : ST_TRIGGERED;
            end
          end
          ST_TRIGGERED: begin
            post_cnt_q <= post_cnt_q - 1'b1;
            if (post_cnt_q == AW'(1)) state_q <= ST_DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // Buffer is owned by the capture path while armed/triggered.
  always_comb begin
    rdata_d = '0;
    if (hit) begin
      if (buf_sel) begin
        rdata_d = capturing ? 32'd0 : 32'(ram_rdata);
      end else begin
        case (off)
          OFF_STATUS:    rdata_d = {23'd0, prefill_ok, 6'd0, state_q};
          OFF_POSTTRIG:  rdata_d = 32'(posttrig_q);
          OFF_TRIG_ADDR: rdata_d = 32'(trig_addr_q);
          OFF_INFO:      rdata_d = info_word(AW, SAMPLE_W);
          default:       rdata_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          bus_rdata_q <= '0;
    else if (bus_ren) bus_rdata_q <= rdata_d;
  end

  assign bus_rdata = bus_rdata_q;

endmodule

// File: tb/tb_ila.sv
// Bench for ila: directed scenarios plus randomized bus/trigger traffic
// against a sample-history reference model.
module tb_ila;

  localparam int          D    = 16;
  localparam int          SW   = 21;
  localparam logic [31:0] BASE = reg_map_pkg::BASE_ILA;

  localparam logic [31:0] A_CTRL   = BASE + 32'h0;
  localparam logic [31:0] A_STATUS = BASE + 32'h4;
  localparam logic [31:0] A_PT     = BASE + 32'h8;
  localparam logic [31:0] A_TA     = BASE + 32'hC;
  localparam logic [31:0] A_INFO   = BASE + 32'h10;
  localparam logic [31:0] A_BUF    = BASE + 32'h8_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          trigger_in;
  logic [SW-1:0] sample_in;
  logic [31:0]   bus_addr, bus_wdata, bus_rdata;
  logic          bus_wen, bus_ren;

  int checks = 0;
  int errors = 0;

  logic [31:0] cyc = 32'd0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 32'd1;
  assign sample_in = cyc[SW-1:0];

  ila #(
    .SAMPLE_W  (SW),
    .DEPTH     (D),
    .BASE_ADDR (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .trigger_in (trigger_in),
    .sample_in  (sample_in),
    .bus_addr   (bus_addr),
    .bus_wen    (bus_wen),
    .bus_ren    (bus_ren),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Reference model: state 0..3, count of samples since arm, samples since trigger.
  int          m_state, m_wptr, m_n, m_after, m_trig, m_pt;
  int          m_buf [D];
  bit          m_val [D];
  bit          m_prev;
  logic [31:0] m_rdata;
  bit          m_rknown;

  task automatic model_step();
    logic [19:0] off;
    bit hit, capt, pre, ctrl, arm, abrt, frc, tc;
    int st0, wp0, pt0, nsat, idx;
    if (rst) begin
      m_state = 0; m_wptr = 0; m_n = 0; m_after = 0; m_trig = 0; m_pt = D / 2;
      m_rdata = '0; m_rknown = 1; m_prev = 1;
      return;
    end
    hit  = (bus_addr[31:20] == BASE[31:20]);
    off  = bus_addr[19:0];
    st0  = m_state; wp0 = m_wptr; pt0 = m_pt;
    capt = (st0 == 1) || (st0 == 2);
    nsat = (m_n > D - 1) ? D - 1 : m_n;
    pre  = (nsat >= D - 1 - pt0);
    if (bus_ren) begin
      m_rknown = 1;
      m_rdata  = '0;
      if (hit) begin
        if (off >= 20'h8_0000 && off < 20'h8_0000 + 20'(4 * D)) begin
          idx = int'(off - 20'h8_0000) / 4;
          if (!capt) begin
            if (m_val[idx]) m_rdata = 32'(m_buf[idx]);
            else            m_rknown = 0;
          end
        end else begin
          case (off)
            20'h4:   m_rdata = (pre ? 32'h100 : 32'h0) | 32'(st0);
            20'h8:   m_rdata = 32'(pt0);
            20'hC:   m_rdata = 32'(m_trig);
            20'h10:  m_rdata = 32'h1A04_0015;
            default: m_rdata = '0;
          endcase
        end
      end
    end
    ctrl = bus_wen && hit && (off == 20'h0);
    arm  = ctrl && bus_wdata[0];
    frc  = ctrl && bus_wdata[1];
    abrt = ctrl && bus_wdata[2];
`ifdef ILA_EDGE_TRIG_EN
    tc = trigger_in && !m_prev;
`else
    tc = trigger_in;
`endif
    m_prev = trigger_in;
    if (capt) begin
      m_buf[wp0] = int'(sample_in);
      m_val[wp0] = 1;
      m_wptr     = (wp0 + 1) % D;
      m_n++;
      if (st0 == 2) m_after++;
    end
    if (bus_wen && hit && off == 20'h8 && (st0 == 0 || st0 == 3))
      m_pt = (bus_wdata > 32'(D - 1)) ? D - 1 : int'(bus_wdata);
    if (arm) begin
      m_state = 1; m_wptr = 0; m_n = 0;
    end else if (abrt) begin
      m_state = 0;
    end else if (st0 == 1 && ((tc && pre) || frc)) begin
      m_trig  = wp0;
      m_after = 0;
      m_state = (pt0 == 0) ? 3 : 2;
    end else if (st0 == 2 && m_after == pt0) begin
      m_state = 3;
    end
  endtask

  always @(posedge clk) model_step();

  // Bus helpers: entered at a negedge, return at the next negedge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    @(negedge clk);
    bus_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    bus_addr = a; bus_ren = 1'b1;
    @(negedge clk);
    bus_ren = 1'b0;
    d = bus_rdata;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d, arm_s, exp;
    int exp_ta, c, st, r;
    logic [19:0] off;
    foreach (m_val[i]) m_val[i] = 0;
    rst = 1'b1; trigger_in = 1'b0;
    bus_addr = '0; bus_wdata = '0; bus_wen = 1'b0; bus_ren = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values and window decode.
    bus_read(A_STATUS, d); chk("rst_status", d, 32'h0);
    bus_read(A_PT, d);     chk("rst_posttrig", d, 32'd8);
    bus_read(A_TA, d);     chk("rst_trigaddr", d, 32'h0);
    bus_read(A_INFO, d);   chk("info", d, 32'h1A04_0015);
    bus_read(32'hF800_0010, d); chk("outside_read", d, 32'h0);
    bus_write(32'hF800_0000, 32'h1);
    bus_read(A_STATUS, d); chk("outside_write", d, 32'h0);

    // Trigger pulse at sample 100 with POSTTRIG=4.
    bus_write(A_PT, 32'd4);
    bus_read(A_PT, d); chk("posttrig_wr", d, 32'd4);
    arm_s = cyc;
    bus_write(A_CTRL, 32'h1);
    for (int i = 0; i < 300 && cyc != 32'd100; i++) @(negedge clk);
    chk("reach_cnt100", cyc, 32'd100);
    trigger_in = 1'b1; bus_addr = A_STATUS; bus_ren = 1'b1;
    for (int j = 0; j <= 6; j++) begin
      @(negedge clk);
      trigger_in = 1'b0;
      exp = (j == 0) ? 32'h101 : ((j <= 4) ? 32'h102 : 32'h103);
      chk("trig_status", bus_rdata, exp);
    end
    bus_ren = 1'b0;
    exp_ta = (100 - int'(arm_s) - 1) % D;
    bus_read(A_TA, d); chk("trig_addr", d, 32'(exp_ta));
    for (int k = 0; k < D; k++) begin
      bus_read(A_BUF + 32'(4 * ((exp_ta + 5 + k) % D)), d);
      chk("buf_chrono", d, 32'(89 + k));
    end

    // Trigger level already high when armed.
    trigger_in = 1'b1;
    bus_write(A_CTRL, 32'h1);
    bus_addr = A_STATUS; bus_ren = 1'b1;
    for (int j = 1; j <= 18; j++) begin
      @(negedge clk);
      c = j - 1;
`ifdef ILA_EDGE_TRIG_EN
      st = 1;
`else
      st = (c <= 11) ? 1 : ((c <= 15) ? 2 : 3);
`endif
      exp = ((c >= 11) ? 32'h100 : 32'h0) | 32'(st);
      chk("level_status", bus_rdata, exp);
    end
    bus_ren = 1'b0; trigger_in = 1'b0;
    bus_write(A_CTRL, 32'h4);

    // FORCE two cycles after ARM; buffer hidden while armed.
    bus_write(A_CTRL, 32'h1);
    bus_read(A_BUF + 32'd12, d); chk("buf_rd_armed", d, 32'h0);
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STATUS, d); chk("force_status", d, 32'h2);
    bus_read(A_TA, d);     chk("force_trigaddr", d, 32'h1);

    // ABORT while triggered.
    bus_write(A_CTRL, 32'h1);
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STATUS, d); chk("pre_abort_status", d, 32'h2);
    bus_write(A_CTRL, 32'h4);
    bus_read(A_STATUS, d); chk("abort_status", d, 32'h0);

    // Reset mid-capture keeps buffer contents.
    bus_write(A_PT, 32'd3);
    bus_write(A_CTRL, 32'h1);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus_read(A_STATUS, d); chk("rst2_status", d, 32'h0);
    bus_read(A_PT, d);     chk("rst2_posttrig", d, 32'd8);
    bus_read(A_TA, d);     chk("rst2_trigaddr", d, 32'h0);
    for (int i = 0; i < D; i++) begin
      bus_read(A_BUF + 32'(4 * i), d);
      chk("buf_keep", d, 32'(m_buf[i]));
    end

    // Read latency and hold.
    bus_read(A_BUF + 32'd20, d); chk("ren_latency", d, 32'(m_buf[5]));
    bus_addr = A_INFO;
    repeat (3) begin
      @(negedge clk);
      chk("ren_hold", bus_rdata, 32'(m_buf[5]));
    end

    // POSTTRIG clamp and write lockout while armed.
    bus_write(A_PT, 32'd100);
    bus_read(A_PT, d); chk("posttrig_clamp", d, 32'd15);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_PT, 32'd2);
    bus_read(A_PT, d); chk("posttrig_locked", d, 32'd15);
    bus_write(A_CTRL, 32'h4);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (m_rknown) chk("rnd_rdata", bus_rdata, m_rdata);
      rst        = ($urandom_range(0, 299) == 0);
      trigger_in = ($urandom_range(0, 19) == 0);
      r          = int'($urandom_range(0, 99));
      bus_wen    = (r < 8);
      bus_ren    = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 9))
        0:       off = 20'h0;
        1:       off = 20'h4;
        2:       off = 20'h8;
        3:       off = 20'hC;
        4:       off = 20'h10;
        5:       off = 20'h14;
        default: off = 20'h8_0000 + 20'(4 * $urandom_range(0, D + 1));
      endcase
      bus_wdata = $urandom;
      if (bus_wen) begin
        if ($urandom_range(0, 1) == 1) begin
          off       = 20'h0;
          bus_wdata = ($urandom_range(0, 7) == 0) ? 32'h4 : 32'($urandom_range(0, 3));
        end else begin
          off       = 20'h8;
          bus_wdata = 32'($urandom_range(0, 40));
        end
      end
      bus_addr = ($urandom_range(0, 19) == 0) ? {12'hF80, off} : {BASE[31:20], off};
    end
    @(negedge clk);
    rst = 1'b0; bus_wen = 1'b0; bus_ren = 1'b0; trigger_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
